// File: rtl/ln_out_serializer.sv
// LayerNorm output serializer: captures a D-element normalized vector, requantizes each
// element (round-half-up shift, then clamp) and streams it out one element per handshake.
module ln_out_serializer #(
  parameter int D     = 4,
  parameter int OUT_W = 17,
  parameter int DW    = 8,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [OUT_W-1:0] in_y [0:D-1],
  output logic                    in_ready,
  output logic                    out_valid,
  output logic signed [DW-1:0]    out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic [7:0]              sat_count
);

  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);
  localparam logic signed [OUT_W:0] RND  = (OUT_W + 1)'((1 << SHIFT) >> 1);
  localparam logic signed [OUT_W:0] QMAX = (OUT_W + 1)'((1 << (DW - 1)) - 1);
  localparam logic signed [OUT_W:0] QMIN = (OUT_W + 1)'(-(1 << (DW - 1)));

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_idx;
  logic signed [DW-1:0]  r_buf [0:D-1];
  logic                  r_overflow;
  logic [7:0]            r_sat_count;

  logic [DW:0]           w_qs [0:D-1];
  logic [8:0]            w_nsat;
  logic [9:0]            w_sat_sum;
  logic                  w_at_last;
  logic                  w_capture;
  logic                  w_drop;
  logic                  w_accept;

  // One extra bit of headroom so the rounding add can never wrap.
  function automatic logic signed [OUT_W:0] round_shift(input logic signed [OUT_W-1:0] y);
    logic signed [OUT_W:0] v;
    v = {y[OUT_W-1], y};
    return (v + RND) >>> SHIFT;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [DW:0] saturate(input logic signed [OUT_W:0] r);
    if (r > QMAX)
      return {1'b1, QMAX[DW-1:0]};
    else if (r < QMIN)
      return {1'b1, QMIN[DW-1:0]};
    else
      return {1'b0, r[DW-1:0]};
  endfunction

  always_comb begin
    w_nsat = '0;
    for (int i = 0; i < D; i++) begin
      w_qs[i] = saturate(round_shift(in_y[i]));
      w_nsat  = w_nsat + 9'(w_qs[i][DW]);
    end
    w_sat_sum = 10'(r_sat_count) + 10'(w_nsat);
  end

  assign w_at_last = (r_idx == LAST_IDX);
  assign w_capture = in_valid && in_ready;
  assign w_drop    = in_valid && !in_ready;
  assign w_accept  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // A capture on the final accept keeps us in SEND, so back-to-back vectors have no bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_capture) w_state_nxt = S_SEND;
      S_SEND: if (w_accept && w_at_last && !w_capture) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    if (r_state == S_SEND) begin
      in_ready  = w_at_last && out_ready;
      out_valid = 1'b1;
      out_last  = w_at_last;
      out_data  = r_buf[r_idx];
    end
  end

  // Capture stage: quantized vector lands in the buffer one cycle after in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_overflow  <= 1'b0;
      r_sat_count <= '0;
      for (int i = 0; i < D; i++) r_buf[i] <= '0;
    end else begin
      if (w_capture) begin
        r_idx       <= '0;
        r_sat_count <= (w_sat_sum > 10'd255) ? 8'hFF : w_sat_sum[7:0];
        for (int i = 0; i < D; i++) r_buf[i] <= w_qs[i][DW-1:0];
      end else if (w_accept && !w_at_last) begin
        r_idx <= r_idx + IW'(1);
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_ln_out_serializer.sv
// Self-checking bench for ln_out_serializer: table of vectors streamed through a scoreboard,
// plus hand sequences for rounding, backpressure, collision, back-to-back and mid-stream reset.
module tb_ln_out_serializer;
  localparam int D = 4, OUT_W = 17, DW = 8;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic signed [OUT_W-1:0] in_y [0:D-1];
  logic in_ready, out_valid, out_last, overflow;
  logic signed [DW-1:0] out_data;
  logic [7:0] sat_count;
  logic s2_in_ready, s2_out_valid, s2_out_last, s2_overflow;
  logic signed [DW-1:0] s2_out_data;
  logic [7:0] s2_sat_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW:0] sb_q [$];

  typedef struct packed {
    logic [D-1:0][OUT_W-1:0] y;
    logic [D-1:0][DW-1:0]    e;
    logic [7:0]              sat;
  } vec_t;
  vec_t tbl [3];

  ln_out_serializer #(.D(D), .OUT_W(OUT_W), .DW(DW), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_y(in_y), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .overflow(overflow), .sat_count(sat_count));

  ln_out_serializer #(.D(D), .OUT_W(OUT_W), .DW(DW), .SHIFT(2)) dut_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_y(in_y), .in_ready(s2_in_ready),
    .out_valid(s2_out_valid), .out_data(s2_out_data), .out_last(s2_out_last), .out_ready(out_ready),
    .overflow(s2_overflow), .sat_count(s2_sat_count));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Samples at the falling edge, pops the scoreboard on a handshake, returns 1 after the rising edge.
  task automatic cyc();
    logic [DW:0] e;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stream_extra: got element %0d, required none", out_data);
      end else begin
        e = sb_q.pop_front();
        chk("stream_data", int'(out_data), int'($signed(e[DW-1:0])));
        chk("stream_last", int'(out_last), int'(e[DW]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input vec_t v, input bit expect_accept);
    in_valid = 1'b1;
    for (int i = 0; i < D; i++) in_y[i] = v.y[i];
    if (expect_accept)
      for (int i = 0; i < D; i++) sb_q.push_back({(i == D - 1), v.e[i]});
  endtask

  function automatic vec_t mk(input int y0, y1, y2, y3, e0, e1, e2, e3, s);
    vec_t v;
    v.y[0] = OUT_W'(y0); v.y[1] = OUT_W'(y1); v.y[2] = OUT_W'(y2); v.y[3] = OUT_W'(y3);
    v.e[0] = DW'(e0);    v.e[1] = DW'(e1);    v.e[2] = DW'(e2);    v.e[3] = DW'(e3);
    v.sat  = 8'(s);
    return v;
  endfunction

  initial begin
    int e2 [4];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < D; i++) in_y[i] = '0;
    // sat field holds the running sat_count expected after the vector is captured
    tbl[0] = mk(5, -3, 127, -128,        5, -3, 127, -128, 0);
    tbl[1] = mk(300, -300, 0, 1,         127, -128, 0, 1,  2);
    tbl[2] = mk(128, -129, -1, -65536,   127, -128, -1, -128, 5);
    e2 = '{2, -1, 1, 0};

    cyc(); cyc();
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data), 0);
    chk("rst_overflow",  int'(overflow), 0);
    chk("rst_sat_count", int'(sat_count), 0);
    chk("rst_in_ready",  int'(in_ready), 1);
    chk("rst_s2_in_ready", int'(s2_in_ready), 1);
    chk("rst_s2_overflow", int'(s2_overflow), 0);
    chk("rst_s2_sat_count", int'(s2_sat_count), 0);

    for (int k = 0; k < 3; k++) begin
      drive_vec(tbl[k], 1'b1);
      chk("tbl_in_ready", int'(in_ready), 1);
      cyc();
      in_valid = 1'b0;
      chk("tbl_lat_valid", int'(out_valid), 1);
      chk("tbl_lat_data", int'(out_data), int'($signed(tbl[k].e[0])));
      repeat (D) cyc();
      chk("tbl_end_valid", int'(out_valid), 0);
      chk("tbl_sat_count", int'(sat_count), int'(tbl[k].sat));
    end

    drive_vec(mk(6, -6, 2, -2, 6, -6, 2, -2, 5), 1'b1);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < D; i++) begin
      chk("s2_valid", int'(s2_out_valid), 1);
      chk("s2_data", int'(s2_out_data), e2[i]);
      chk("s2_last", int'(s2_out_last), int'(i == D - 1));
      cyc();
    end
    chk("s2_sat_count", int'(sat_count), 5);

    out_ready = 1'b0;
    drive_vec(tbl[0], 1'b1);
    cyc();
    in_valid = 1'b0;
    repeat (3) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), 5);
      chk("bp_last", int'(out_last), 0);
      chk("bp_in_ready", int'(in_ready), 0);
      cyc();
    end
    out_ready = 1'b1;
    repeat (D) cyc();
    chk("bp_done_valid", int'(out_valid), 0);

    drive_vec(tbl[1], 1'b1);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("col_idx1_data", int'(out_data), -128);
    drive_vec(tbl[2], 1'b0);
    chk("col_in_ready", int'(in_ready), 0);
    cyc();
    in_valid = 1'b0;
    chk("col_overflow", int'(overflow), 1);
    cyc(); cyc();
    chk("col_done_valid", int'(out_valid), 0);
    chk("col_sat_count", int'(sat_count), 7);

    drive_vec(tbl[0], 1'b1);
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("b2b_last", int'(out_last), 1);
    drive_vec(tbl[2], 1'b1);
    chk("b2b_in_ready", int'(in_ready), 1);
    cyc();
    in_valid = 1'b0;
    chk("b2b_no_gap", int'(out_valid), 1);
    chk("b2b_data", int'(out_data), 127);
    repeat (D) cyc();
    chk("b2b_done_valid", int'(out_valid), 0);
    chk("b2b_sat_count", int'(sat_count), 10);
    chk("b2b_overflow_sticky", int'(overflow), 1);

    drive_vec(tbl[0], 1'b1);
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    chk("rm_idx2_data", int'(out_data), 127);
    out_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    sb_q.delete();
    chk("rm_valid", int'(out_valid), 0);
    chk("rm_in_ready", int'(in_ready), 1);
    chk("rm_overflow", int'(overflow), 0);
    chk("rm_sat_count", int'(sat_count), 0);
    repeat (2) begin
      cyc();
      chk("rm_idle_valid", int'(out_valid), 0);
    end
    drive_vec(tbl[1], 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("rm_restart_valid", int'(out_valid), 1);
    chk("rm_restart_data", int'(out_data), 127);
    repeat (D) cyc();
    chk("rm_restart_sat", int'(sat_count), 2);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ln_out_serializer.md
LN_OUT_SERIALIZER -- requirements
Module: ln_out_serializer

Interface
REQ-001 Parameters SHALL be: D, default 4, vector length; OUT_W, default 17, width of each input element; DW, default 8, width of each output element; SHIFT, default 0, right-shift applied before saturation.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  pulse marking in_y as a valid normalized vector.
REQ-005 in_y  input  D x OUT_W signed (array [0:D-1])  normalized LayerNorm output vector.
REQ-006 in_ready  output  1  block can capture a vector this cycle.
REQ-007 out_valid  output  1  out_data holds a valid element.
REQ-008 out_data  output  DW signed  requantized element.
REQ-009 out_last  output  1  current element is index D-1.
REQ-010 out_ready  input  1  downstream accepts the element this cycle.
REQ-011 overflow  output  1  sticky flag; a vector was dropped.
REQ-012 sat_count  output  8  saturating count of clamped elements.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and SEND.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 In SEND, in_ready SHALL equal (idx==D-1 && out_ready), a combinational path from out_ready.
REQ-016 On in_valid && in_ready, the block SHALL register all D quantized elements into an internal buffer, set idx=0 and enter SEND.
REQ-017 Latency SHALL be 1 cycle: capture edge at cycle t gives out_valid=1 with element 0 during cycle t+1.
REQ-018 Quantize SHALL operate per element as follows:
- r = (y + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, an arithmetic shift (round half up), with no intermediate overflow (OUT_W+1 bits).
- Clamp r to [-2^(DW-1), 2^(DW-1)-1].
REQ-019 sat_count SHALL increment by the number of clamped elements in each captured vector and saturate at 255.
REQ-020 In SEND, out_data SHALL equal buf[idx], out_valid SHALL be 1, and out_last SHALL be (idx==D-1).
REQ-021 On out_valid && out_ready with idx<D-1, idx SHALL increment.
REQ-022 On out_valid && out_ready with idx==D-1, the FSM SHALL return to IDLE.
REQ-023 If in_valid is also high in that cycle (REQ-022), the new vector SHALL be captured and the FSM SHALL stay in SEND with idx=0, giving no bubble.
REQ-024 While out_ready is 0, out_data, out_last and idx SHALL hold.
REQ-025 in_valid while in_ready=0 SHALL drop the vector, set overflow=1 and leave the buffer, idx and state unchanged.
REQ-026 overflow SHALL remain 1 until reset.
REQ-027 in_valid in IDLE and out_ready values in IDLE SHALL have no effect on idx.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL set:
- state=IDLE, idx=0, buffer=0;
- out_valid=0, out_data=0, out_last=0;
- overflow=0, sat_count=0.
REQ-029 rst asserted mid-SEND SHALL abort the vector: out_valid SHALL be 0 from the following cycle and no remaining elements SHALL be emitted.
REQ-030 in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-031 Reset: apply rst for 2 cycles -> out_valid=0, out_data=0, overflow=0, sat_count=0, in_ready=1.
REQ-032 Basic: in_y={5,-3,127,-128} with out_ready=1 -> out_data 5,-3,127,-128 on cycles t+1..t+4; out_last=1 only on the 4th; sat_count=0.
REQ-033 Saturation and rounding:
- Default parameters: in_y={300,-300,0,1} -> 127,-128,0,1; sat_count=2.
- SHIFT=2: in_y={6,-6,2,-2} -> 2,-1,1,0.
REQ-034 Backpressure: out_ready=0 for 3 cycles after capture of {5,-3,127,-128} -> out_data held at 5 with out_valid=1; the stream resumes in order when out_ready rises.
REQ-035 Collision and back-to-back:
- in_valid with idx=1 -> vector dropped, overflow=1, original stream completes unchanged.
- in_valid in the cycle the last element is accepted -> new element 0 appears on the next cycle with no out_valid gap.
REQ-036 Reset mid-stream: rst asserted with idx=2 -> out_valid=0 the next cycle, in_ready=1, and a subsequent vector streams from index 0.
